npu_mac_wpack: RTL and testbench

Output write-packer that sits directly downstream of the MAC datapath, between the MAC result stream (`t2`) and the store-side LSU channel. It collects consecutive `O_LEN`-bit results into `BUS_W`-bit bus words and buffers completed words in a small FIFO. It drains them to the LSU with a valid/ready handshake and raises an almost-full flag so the CU can stop issuing MAC operands before results are lost.

---
 rtl/npu_pkg.sv | 6 +
 rtl/npu_sync_fifo.sv | 56 +++++
 rtl/npu_mac_wpack.sv | 102 ++++++++++
 tb/tb_npu_mac_wpack.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU datapath constants.
// O_LEN: MAC result width; BUS_W: LSU data bus width.
package npu_pkg;
   localparam int O_LEN = 8;
   localparam int BUS_W = 32;
endpackage

// File: rtl/npu_sync_fifo.sv
// Generic show-ahead synchronous FIFO; head entry is visible on data_o.
// Ports: clk_i, arstn_i, clr_i (sync clear), push_i/data_i, pop_i/data_o,
// empty_o, full_o, cnt_o (occupancy).
module npu_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          arstn_i,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [AW:0]   cnt_o
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (cnt_o == '0);
   assign full_o  = (cnt_o == (AW+1)'(DEPTH));
   // A push on full is accepted only when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   // Empty reads as zero so the bus idles at its reset value.
   assign data_o  = empty_o ? '0 : mem[rptr];

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt_o <= '0;
      end else if (clr_i) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt_o <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         if (do_push && !do_pop)      cnt_o <= cnt_o + 1'b1;
         else if (do_pop && !do_push) cnt_o <= cnt_o - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clr_i) mem[wptr] <= data_i;
   end

endmodule

// File: rtl/npu_mac_wpack.sv
// Packs MAC results little-endian into bus words and queues them for the LSU.
// Ports: t2 result stream in, flush/clear controls, wr_* valid/ready out,
// afull_o / idle_o status, sticky ovf_o on a dropped word.
module npu_mac_wpack #(
   parameter int O_LEN = npu_pkg::O_LEN,
   parameter int BUS_W = npu_pkg::BUS_W,
   parameter int DEPTH = 4
) (
   input  logic               clk_i,
   input  logic               arstn_i,
   input  logic               clear_i,
   input  logic               t2_v_i,
   input  logic [O_LEN-1:0]   t2_i,
   input  logic               flush_i,
   output logic               wr_v_o,
   output logic [BUS_W-1:0]   wr_data_o,
   output logic [BUS_W/8-1:0] wr_be_o,
   input  logic               wr_rdy_i,
   output logic               afull_o,
   output logic               idle_o,
   output logic               ovf_o
);

   localparam int LANES = BUS_W / O_LEN;
   localparam int BEW   = BUS_W / 8;
   localparam int BPL   = O_LEN / 8;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int AW    = $clog2(DEPTH);

   logic [LW-1:0]        lane;
   logic [BUS_W-1:0]     shadow;
   logic [BUS_W-1:0]     word;
   logic [BEW-1:0]       be;
   logic [LW:0]          fill;
   logic                 full_word;
   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [AW:0]          cnt;
   logic [BEW+BUS_W-1:0] head;

   // Current result is merged before deciding on a push, so a flush
   // alongside the last lane yields one full word and nothing more.
   always_comb begin
      word = shadow;
      if (t2_v_i) word[lane*O_LEN +: O_LEN] = t2_i;
      full_word = t2_v_i && (lane == LW'(LANES-1));
      fill      = {1'b0, lane} + (LW+1)'(t2_v_i);
      push      = !clear_i && (full_word || (flush_i && fill != '0));
      be        = '0;
      for (int k = 0; k < LANES; k++) begin
         if (k < int'(fill)) be[k*BPL +: BPL] = '1;
      end
   end

   assign pop = !fifo_empty && wr_rdy_i;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         lane   <= '0;
         shadow <= '0;
         ovf_o  <= 1'b0;
      end else if (clear_i) begin
         lane   <= '0;
         shadow <= '0;
         ovf_o  <= 1'b0;
      end else begin
         // Shadow is zeroed on every push so unfilled lanes read as 0.
         if (push) begin
            lane   <= '0;
            shadow <= '0;
         end else if (t2_v_i) begin
            lane   <= lane + 1'b1;
            shadow <= word;
         end
         if (push && fifo_full && !pop) ovf_o <= 1'b1;
      end
   end

   npu_sync_fifo #(
      .W     (BEW + BUS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .clr_i   (clear_i),
      .push_i  (push),
      .data_i  ({be, word}),
      .pop_i   (pop),
      .data_o  (head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .cnt_o   (cnt)
   );

   assign wr_v_o               = !fifo_empty;
   assign {wr_be_o, wr_data_o} = head;
   assign afull_o              = (cnt >= (AW+1)'(DEPTH-1));
   assign idle_o               = fifo_empty && (lane == '0);

endmodule

// File: tb/tb_npu_mac_wpack.sv
// Self-checking bench for npu_mac_wpack against a queue-based reference.
// Model: pending results list plus a bounded word queue.
module tb_npu_mac_wpack;

   localparam int OL  = 8;
   localparam int BW  = 32;
   localparam int DP  = 4;
   localparam int LN  = BW / OL;
   localparam int BEW = BW / 8;

   logic           clk = 1'b0;
   logic           arstn = 1'b0;
   logic           clear = 1'b0;
   logic           t2_v = 1'b0;
   logic [OL-1:0]  t2 = '0;
   logic           flush = 1'b0;
   logic           rdy = 1'b0;
   logic           wr_v;
   logic [BW-1:0]  wr_data;
   logic [BEW-1:0] wr_be;
   logic           afull;
   logic           idle;
   logic           ovf;

   logic [OL-1:0]      pend[$];
   logic [BEW+BW-1:0]  q[$];
   bit                 m_ovf;
   int                 pass_n = 0;
   int                 total_n = 0;

   npu_mac_wpack #(.O_LEN(OL), .BUS_W(BW), .DEPTH(DP)) dut (
      .clk_i     (clk),
      .arstn_i   (arstn),
      .clear_i   (clear),
      .t2_v_i    (t2_v),
      .t2_i      (t2),
      .flush_i   (flush),
      .wr_v_o    (wr_v),
      .wr_data_o (wr_data),
      .wr_be_o   (wr_be),
      .wr_rdy_i  (rdy),
      .afull_o   (afull),
      .idle_o    (idle),
      .ovf_o     (ovf)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model at the edge,
   // and return at the following falling edge for sampling.
   task automatic step(input bit v, input logic [OL-1:0] d, input bit fl,
                       input bit r, input bit cl);
      logic [BW-1:0]  w;
      logic [BEW-1:0] b;
      bit             mk;
      bit             pop;
      t2_v = v; t2 = d; flush = fl; rdy = r; clear = cl;
      @(posedge clk);
      pop = (q.size() > 0) && r;
      mk  = 1'b0;
      w   = '0;
      b   = '0;
      if (cl) begin
         pend.delete();
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if (v) pend.push_back(d);
         if (pend.size() == LN || (fl && pend.size() > 0)) begin
            foreach (pend[i]) begin
               w[i*OL +: OL]         = pend[i];
               b[i*(OL/8) +: (OL/8)] = '1;
            end
            pend.delete();
            mk = 1'b1;
         end
         if (pop) void'(q.pop_front());
         if (mk) begin
            if (q.size() < DP) q.push_back({b, w});
            else m_ovf = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      total_n++;
      if ({wr_v, wr_data, wr_be, afull, idle, ovf} !==
          {1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0})
         $display("FAIL reset: got v=%b d=%h be=%h af=%b idle=%b ovf=%b",
                  wr_v, wr_data, wr_be, afull, idle, ovf);
      else pass_n++;
   endtask

   task automatic test_full_words();
      int vcnt;
      logic [OL-1:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      vcnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, vals[i], 1'b0, 1'b1, 1'b0);
         if (wr_v) vcnt++;
      end
      total_n++;
      if ({wr_v, wr_data, wr_be} !== {1'b1, 32'h44332211, 4'hF})
         $display("FAIL full_word: got v=%b %h/%h need 1 44332211/f",
                  wr_v, wr_data, wr_be);
      else pass_n++;
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (wr_v) vcnt++;
      total_n++;
      if (vcnt !== 1)
         $display("FAIL full_word_vcycles: got %0d need 1", vcnt);
      else pass_n++;
   endtask

   task automatic test_partial_flush();
      step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
      total_n++;
      if (wr_v !== 1'b0 || idle !== 1'b0)
         $display("FAIL partial_hold: got v=%b idle=%b need 0 0", wr_v, idle);
      else pass_n++;
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      total_n++;
      if ({wr_v, wr_data, wr_be} !== {1'b1, 32'h0000BBAA, 4'h3})
         $display("FAIL partial_flush: got v=%b %h/%h need 1 0000bbaa/3",
                  wr_v, wr_data, wr_be);
      else pass_n++;
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      total_n++;
      if (wr_v !== 1'b0 || idle !== 1'b1)
         $display("FAIL empty_flush: got v=%b idle=%b need 0 1", wr_v, idle);
      else pass_n++;
   endtask

   task automatic test_same_cycle_flush();
      step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h04, 1'b1, 1'b1, 1'b0);
      total_n++;
      if ({wr_v, wr_data, wr_be} !== {1'b1, 32'h04030201, 4'hF})
         $display("FAIL same_cycle: got v=%b %h/%h need 1 04030201/f",
                  wr_v, wr_data, wr_be);
      else pass_n++;
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      total_n++;
      if (wr_v !== 1'b0 || idle !== 1'b1)
         $display("FAIL same_cycle_extra: got v=%b idle=%b need 0 1",
                  wr_v, idle);
      else pass_n++;
   endtask

   task automatic test_overflow();
      logic [BEW+BW-1:0] exp_w [4];
      logic [BW-1:0]     held;
      int words;
      int j;
      bit af_bad;
      bit hold_bad;
      af_bad   = 1'b0;
      hold_bad = 1'b0;
      held     = '0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, OL'($urandom), 1'b0, 1'b0, 1'b0);
         words = (i + 1) / 4;
         if (words == 1 && (i % 4) == 3) held = wr_data;
         if (words >= 1 && wr_data !== held) hold_bad = 1'b1;
         if (afull !== (words >= 3)) af_bad = 1'b1;
         if (i == 15) begin
            for (int k = 0; k < 4; k++) exp_w[k] = q[k];
            total_n++;
            if (ovf !== 1'b0)
               $display("FAIL ovf_early: got %b need 0", ovf);
            else pass_n++;
         end
      end
      total_n++;
      if (af_bad) $display("FAIL afull_rise: got mismatch need rise at word 3");
      else pass_n++;
      total_n++;
      if (hold_bad) $display("FAIL stall_hold: got %h need %h", wr_data, held);
      else pass_n++;
      total_n++;
      if (ovf !== 1'b1) $display("FAIL ovf_set: got %b need 1", ovf);
      else pass_n++;
      j = 0;
      for (int c = 0; c < 8; c++) begin
         if (wr_v) begin
            total_n++;
            if (j >= 4 || {wr_be, wr_data} !== exp_w[j])
               $display("FAIL drain_word%0d: got %h need %h", j,
                        {wr_be, wr_data}, (j < 4) ? exp_w[j] : '0);
            else pass_n++;
            j++;
         end
         step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      end
      total_n++;
      if (j !== 4) $display("FAIL drain_count: got %0d need 4", j);
      else pass_n++;
      total_n++;
      if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b need 1", ovf);
      else pass_n++;
   endtask

   task automatic test_clear();
      logic [OL-1:0] v [4];
      step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b1);
      total_n++;
      if ({wr_v, idle, ovf, afull} !== 4'b0100)
         $display("FAIL clear: got v=%b idle=%b ovf=%b af=%b need 0 1 0 0",
                  wr_v, idle, ovf, afull);
      else pass_n++;
      for (int i = 0; i < 4; i++) begin
         v[i] = OL'($urandom);
         step(1'b1, v[i], 1'b0, 1'b1, 1'b0);
      end
      total_n++;
      if ({wr_v, wr_data, wr_be} !== {1'b1, v[3], v[2], v[1], v[0], 4'hF})
         $display("FAIL clear_next_word: got %h/%h need %h/f",
                  wr_data, wr_be, {v[3], v[2], v[1], v[0]});
      else pass_n++;
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int c = 0; c < 400; c++) begin
         step(($urandom_range(0, 3) != 0), OL'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 63) == 0));
         total_n++;
         if (wr_v !== (q.size() > 0) ||
             (q.size() > 0 && {wr_be, wr_data} !== q[0]) ||
             afull !== (q.size() >= DP - 1) ||
             idle !== (q.size() == 0 && pend.size() == 0) ||
             ovf !== m_ovf) begin
            if (bad < 10)
               $display("FAIL random_c%0d: got v=%b %h/%h af=%b idle=%b ovf=%b need q=%0d head=%h ovf=%b",
                        c, wr_v, wr_data, wr_be, afull, idle, ovf,
                        q.size(), (q.size() > 0) ? q[0] : '0, m_ovf);
            bad++;
         end else pass_n++;
      end
   endtask

   task automatic test_async_reset();
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++)
         step(1'b1, OL'($urandom), 1'b0, 1'b0, 1'b0);
      total_n++;
      if (wr_v !== 1'b1 || q.size() != 2)
         $display("FAIL rst_setup: got v=%b need 1", wr_v);
      else pass_n++;
      #2 arstn = 1'b0;
      #1;
      total_n++;
      if ({wr_v, wr_data, wr_be, afull, idle, ovf} !==
          {1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0})
         $display("FAIL async_reset: got v=%b d=%h be=%h af=%b idle=%b ovf=%b",
                  wr_v, wr_data, wr_be, afull, idle, ovf);
      else pass_n++;
      pend.delete();
      q.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      arstn = 1'b1;
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      total_n++;
      if (wr_v !== 1'b0 || idle !== 1'b1)
         $display("FAIL post_reset: got v=%b idle=%b need 0 1", wr_v, idle);
      else pass_n++;
   endtask

   initial begin
      m_ovf = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      arstn = 1'b1;
      @(negedge clk);
      test_full_words();
      test_partial_flush();
      test_same_cycle_flush();
      test_overflow();
      test_clear();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
